// File: rtl/axis_processor_arbiter_pkg.sv
// Shared configuration for the processor arbiter.
// processor_config carries the processor's stream widths.
// arbiter_config carries the FSM state type, default sizes and a round-robin helper.
package processor_config;
  localparam int INP_WIDTH = 32;
  localparam int OUT_WIDTH = 16;
endpackage

package arbiter_config;
  import processor_config::*;

  localparam int DEF_NUM_REQ   = 4;
  localparam int REQ_ID_WIDTH  = $clog2(DEF_NUM_REQ);
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, INPUT, DRAIN} state_t;
  typedef logic [INP_WIDTH-1:0] inp_word_t;
  typedef logic [OUT_WIDTH-1:0] out_word_t;

  // First set bit of valid, searching upward from ptr with wrap.
  function automatic logic [REQ_ID_WIDTH-1:0] rr_pick(input logic [DEF_NUM_REQ-1:0] valid,
                                                      input logic [REQ_ID_WIDTH-1:0] ptr);
    logic [REQ_ID_WIDTH-1:0] idx;
    int j;
    idx = ptr;
    for (int i = DEF_NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % DEF_NUM_REQ;
      if (valid[j]) idx = REQ_ID_WIDTH'(j);
    end
    return idx;
  endfunction
endpackage

// File: rtl/axis_processor_arbiter_if.sv
// Requester-side and processor-side stream bundle for the arbiter.
// master: host demux + processor (drives requests and processor outputs).
// slave:  the arbiter.
interface axis_processor_arbiter_if
  import processor_config::*;
  import arbiter_config::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();
  logic [NUM_REQ-1:0][INP_WIDTH-1:0] s_req_tdata;
  logic [NUM_REQ-1:0]                s_req_tvalid;
  logic [NUM_REQ-1:0]                s_req_tlast;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] s_req_tuser;
  logic [NUM_REQ-1:0]                s_req_tready;
  logic [NUM_REQ-1:0][OUT_WIDTH-1:0] m_req_tdata;
  logic [NUM_REQ-1:0]                m_req_tvalid;
  logic [NUM_REQ-1:0]                m_req_tready;
  logic [INP_WIDTH-1:0]              p_s_axis_tdata;
  logic                              p_s_axis_tvalid;
  logic                              p_s_axis_tready;
  logic [OUT_WIDTH-1:0]              p_m_axis_tdata;
  logic                              p_m_axis_tvalid;
  logic                              p_m_axis_tready;

  modport master (
    output s_req_tdata, s_req_tvalid, s_req_tlast, s_req_tuser, m_req_tready,
    output p_s_axis_tready, p_m_axis_tdata, p_m_axis_tvalid,
    input  s_req_tready, m_req_tdata, m_req_tvalid,
    input  p_s_axis_tdata, p_s_axis_tvalid, p_m_axis_tready
  );

  modport slave (
    input  s_req_tdata, s_req_tvalid, s_req_tlast, s_req_tuser, m_req_tready,
    input  p_s_axis_tready, p_m_axis_tdata, p_m_axis_tvalid,
    output s_req_tready, m_req_tdata, m_req_tvalid,
    output p_s_axis_tdata, p_s_axis_tvalid, p_m_axis_tready
  );
endinterface

// File: rtl/axis_processor_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first valid index at or after ptr.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  // Scan from the far end so the entry closest to ptr is written last and wins.
  always_comb begin
    int j;
    j     = 0;
    found = |valid;
    idx   = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (valid[j]) idx = W'(j);
    end
  end
endmodule

// File: rtl/axis_processor_arbiter.sv
// Round-robin owner arbiter sharing one stream processor among NUM_REQ requesters.
// A grant lasts until the input packet has ended and the declared output count
// has come back, so outputs are never interleaved between requesters.
// Optional drain watchdog: define ARB_TIMEOUT_EN.
module axis_processor_arbiter
  import arbiter_config::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int REQ_ID_WIDTH = $clog2(NUM_REQ),
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                    clk,
  input  logic                    arst,
  axis_processor_arbiter_if.slave bus,
  output logic                    busy,
  output logic [REQ_ID_WIDTH-1:0] owner
`ifdef ARB_TIMEOUT_EN
  , output logic                  timeout_err
`endif
);
  state_t                  state_q, state_d;
  logic [REQ_ID_WIDTH-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, owner_nxt;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d, rem_base, rem_dec;
  logic                    first_q, first_d, pick_found, in_hs, out_hs;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d;
  assign timeout_err = terr_q;
`endif

  rr_picker #(.N(NUM_REQ), .W(REQ_ID_WIDTH)) u_pick (
    .valid (bus.s_req_tvalid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign in_hs     = (state_q == INPUT) && bus.s_req_tvalid[owner_q] && bus.p_s_axis_tready;
  assign out_hs    = (state_q != IDLE) && bus.p_m_axis_tvalid && bus.m_req_tready[owner_q];
  assign owner_nxt = (owner_q == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // The count is sampled on the first beat, then any same-cycle output is taken off it.
  assign rem_base  = (in_hs && first_q) ? bus.s_req_tuser[owner_q] : remaining_q;
  assign rem_dec   = (out_hs && rem_base != '0) ? rem_base - 1'b1 : rem_base;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
`ifdef ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      terr_q      <= terr_d;
`endif
    end
  end

  // Next-state: grant, end-of-input test, drain completion.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    if (state_q != IDLE) remaining_d = rem_dec;
    if (in_hs) first_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    terr_d = terr_q;
    wd_d   = '0;
    if (state_q == DRAIN && !out_hs) wd_d = wd_q + 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          first_d = 1'b1;
          state_d = INPUT;
        end
      end
      INPUT: begin
        if (in_hs && bus.s_req_tlast[owner_q]) begin
          if (rem_dec == '0) begin
            state_d  = IDLE;
            rr_ptr_d = owner_nxt;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs && rem_dec == '0) begin
          state_d  = IDLE;
          rr_ptr_d = owner_nxt;
        end
`ifdef ARB_TIMEOUT_EN
        // Processor stopped returning words: give up the grant and flag it.
        if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
          state_d     = IDLE;
          rr_ptr_d    = owner_nxt;
          remaining_d = '0;
          wd_d        = '0;
          terr_d      = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: owner-indexed muxes, every non-owner lane held at 0.
  always_comb begin
    bus.s_req_tready          = '0;
    bus.m_req_tvalid          = '0;
    bus.m_req_tdata           = '0;
    bus.p_s_axis_tvalid       = 1'b0;
    bus.p_m_axis_tready       = 1'b0;
    bus.p_s_axis_tdata        = bus.s_req_tdata[owner_q];
    bus.m_req_tdata[owner_q]  = bus.p_m_axis_tdata;
    if (state_q == INPUT) begin
      bus.p_s_axis_tvalid          = bus.s_req_tvalid[owner_q];
      bus.s_req_tready[owner_q]    = bus.p_s_axis_tready;
    end
    if (state_q != IDLE) begin
      bus.m_req_tvalid[owner_q]    = bus.p_m_axis_tvalid;
      bus.p_m_axis_tready          = bus.m_req_tready[owner_q];
    end
  end
endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Directed bench for axis_processor_arbiter: grant order, drain counting,
// coincident last/output, async reset, and (with ARB_TIMEOUT_EN) the watchdog.
module tb_axis_processor_arbiter;
  import arbiter_config::*;

  logic clk = 1'b0;
  logic arst;
  logic busy;
  logic [1:0] owner;
`ifdef ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  int n_vec = 0;
  int n_bad = 0;

  axis_processor_arbiter_if #(.NUM_REQ(4), .CNT_WIDTH(16)) bus ();

  axis_processor_arbiter #(
    .NUM_REQ(4), .REQ_ID_WIDTH(2), .CNT_WIDTH(16)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk   (clk),
    .arst  (arst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    arst = 1'b1;
    bus.s_req_tdata     = '0;
    bus.s_req_tvalid    = '0;
    bus.s_req_tlast     = '0;
    bus.s_req_tuser     = '0;
    bus.m_req_tready    = '1;
    bus.p_s_axis_tready = 1'b1;
    bus.p_m_axis_tdata  = '0;
    bus.p_m_axis_tvalid = 1'b0;
    tick(); tick();
    chk("rst_busy",    busy, 0);
    chk("rst_owner",   owner, 0);
    chk("rst_sready",  bus.s_req_tready, 0);
    chk("rst_mvalid",  bus.m_req_tvalid, 0);
    chk("rst_psvalid", bus.p_s_axis_tvalid, 0);
    chk("rst_pmready", bus.p_m_axis_tready, 0);
    arst = 1'b0;

    // Requester 2: tuser=3, four input beats, three output words.
    tick();
    bus.s_req_tvalid = 4'b0100; bus.s_req_tdata[2] = 32'hA0; bus.s_req_tuser[2] = 16'd3;
    #1;
    chk("grant_cycle_busy",   busy, 0);
    chk("grant_cycle_sready", bus.s_req_tready, 0);
    tick(); #1;
    chk("t1_owner",   owner, 2);
    chk("t1_busy",    busy, 1);
    chk("t1_sready",  bus.s_req_tready, 4'b0100);
    chk("t1_psvalid", bus.p_s_axis_tvalid, 1);
    chk("t1_psdata",  bus.p_s_axis_tdata, 32'hA0);
    tick();
    bus.s_req_tdata[2] = 32'hA1; bus.p_m_axis_tvalid = 1'b1; bus.p_m_axis_tdata = 16'h0055;
    #1;
    chk("t1_mvalid",  bus.m_req_tvalid, 4'b0100);
    chk("t1_mdata",   bus.m_req_tdata[2], 16'h0055);
    chk("t1_mdata0",  bus.m_req_tdata[0], 16'h0000);
    chk("t1_pmready", bus.p_m_axis_tready, 1);
    chk("t1_psdata2", bus.p_s_axis_tdata, 32'hA1);
    tick();
    bus.s_req_tdata[2] = 32'hA2; bus.p_m_axis_tvalid = 1'b0;
    #1;
    chk("t1_mvalid_off", bus.m_req_tvalid, 0);
    tick();
    bus.s_req_tdata[2] = 32'hA3; bus.s_req_tlast[2] = 1'b1;
    #1;
    chk("t1_last_sready", bus.s_req_tready, 4'b0100);
    tick();
    bus.s_req_tvalid = '0; bus.s_req_tlast = '0;
    bus.p_m_axis_tvalid = 1'b1; bus.p_m_axis_tdata = 16'h0066;
    #1;
    chk("t1_drain_busy",    busy, 1);
    chk("t1_drain_sready",  bus.s_req_tready, 0);
    chk("t1_drain_psvalid", bus.p_s_axis_tvalid, 0);
    chk("t1_drain_mvalid",  bus.m_req_tvalid, 4'b0100);
    tick();
    bus.p_m_axis_tdata = 16'h0077;
    #1;
    chk("t1_drain_last_busy", busy, 1);
    tick();
    bus.p_m_axis_tvalid = 1'b0;
    // Idle cycle after the third word; requesters 3 and 0 both ask, tuser=0, tlast.
    bus.s_req_tvalid = 4'b1001; bus.s_req_tlast = 4'b1001;
    bus.s_req_tuser[3] = 16'd0; bus.s_req_tuser[0] = 16'd0;
    bus.s_req_tdata[3] = 32'hD3; bus.s_req_tdata[0] = 32'hD0;
    #1;
    chk("t1_idle_busy",  busy, 0);
    chk("t1_idle_owner", owner, 2);

    // rr_ptr now 3: requester 3 wins over 0. tuser=0 single beat.
    tick(); #1;
    chk("rr3_owner",  owner, 3);
    chk("rr3_busy",   busy, 1);
    chk("rr3_sready", bus.s_req_tready, 4'b1000);
    chk("rr3_psdata", bus.p_s_axis_tdata, 32'hD3);
    tick();
    // rr_ptr now 0; requesters 0 and 1 together.
    bus.s_req_tvalid = 4'b0011; bus.s_req_tlast = 4'b0001;
    bus.s_req_tuser[0] = 16'd2; bus.s_req_tuser[1] = 16'd1;
    #1;
    chk("tuser0_busy_one_cycle", busy, 0);
    tick(); #1;
    chk("t2_owner0",      owner, 0);
    chk("t2_req1_blocked", bus.s_req_tready, 4'b0001);
    tick();
    bus.s_req_tvalid = 4'b0010;
    bus.p_m_axis_tvalid = 1'b1; bus.p_m_axis_tdata = 16'h0011;
    #1;
    chk("t2_drain_busy",    busy, 1);
    chk("t2_drain_mvalid",  bus.m_req_tvalid, 4'b0001);
    chk("t2_drain_sready",  bus.s_req_tready, 0);
    tick();
    bus.p_m_axis_tdata = 16'h0012;
    #1;
    chk("t2_drain_mvalid2", bus.m_req_tvalid, 4'b0001);
    tick();
    bus.p_m_axis_tvalid = 1'b0;
    #1;
    chk("t2_idle_busy", busy, 0);
    tick(); #1;
    chk("t2_owner1",  owner, 1);
    chk("t2_sready1", bus.s_req_tready, 4'b0010);
    // Second beat carries tlast while the final output word returns.
    tick();
    bus.s_req_tlast[1] = 1'b1;
    bus.p_m_axis_tvalid = 1'b1; bus.p_m_axis_tdata = 16'h0021;
    #1;
    chk("coinc_mvalid", bus.m_req_tvalid, 4'b0010);
    tick();
    bus.s_req_tvalid = '0; bus.s_req_tlast = '0; bus.p_m_axis_tvalid = 1'b0;
    #1;
    chk("coinc_no_drain", busy, 0);

    // Reset during DRAIN with remaining=5.
    bus.s_req_tvalid = 4'b0100; bus.s_req_tuser[2] = 16'd5; bus.s_req_tlast[2] = 1'b1;
    tick(); #1;
    chk("rst_t_owner", owner, 2);
    tick();
    bus.s_req_tvalid = 4'b1010; bus.s_req_tlast = 4'b1010;
    bus.s_req_tuser[1] = 16'd0; bus.s_req_tuser[3] = 16'd0;
    bus.p_m_axis_tvalid = 1'b1;
    #1;
    chk("rst_t_drain_busy",   busy, 1);
    chk("rst_t_drain_mvalid", bus.m_req_tvalid, 4'b0100);
    #1;
    arst = 1'b1;
    #1;
    chk("arst_busy",    busy, 0);
    chk("arst_owner",   owner, 0);
    chk("arst_mvalid",  bus.m_req_tvalid, 0);
    chk("arst_pmready", bus.p_m_axis_tready, 0);
    chk("arst_sready",  bus.s_req_tready, 0);
    @(posedge clk); #2;
    arst = 1'b0; bus.p_m_axis_tvalid = 1'b0;
    tick(); #1;
    chk("arst_rr_ptr0_owner", owner, 1);
    chk("arst_regrant_busy",  busy, 1);
    tick();
    bus.s_req_tvalid = 4'b1000;
    #1;
    chk("arst_after_busy", busy, 0);
    tick(); #1;
    chk("arst_next_owner", owner, 3);
    tick();
    bus.s_req_tvalid = '0; bus.s_req_tlast = '0;
    #1;
    chk("arst_final_idle", busy, 0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: tuser=2, only one word returns.
    bus.s_req_tvalid = 4'b0001; bus.s_req_tuser[0] = 16'd2; bus.s_req_tlast[0] = 1'b1;
    #1;
    chk("to_err_clear", timeout_err, 0);
    tick(); #1;
    chk("to_owner", owner, 0);
    tick();
    bus.s_req_tvalid = '0; bus.p_m_axis_tvalid = 1'b1;
    #1;
    chk("to_drain_busy", busy, 1);
    tick();
    bus.p_m_axis_tvalid = 1'b0;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_stall_busy_%0d", k), busy, 1);
      chk($sformatf("to_stall_err_%0d", k), timeout_err, 0);
      tick(); #1;
    end
    chk("to_idle_busy", busy, 0);
    chk("to_err_set",   timeout_err, 1);
    bus.s_req_tvalid = 4'b0010; bus.s_req_tuser[1] = 16'd0; bus.s_req_tlast[1] = 1'b1;
    tick(); #1;
    chk("to_next_owner", owner, 1);
    tick(); #1;
    chk("to_err_sticky", timeout_err, 1);
    bus.s_req_tvalid = '0;
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
